md5_match_checker: RTL and testbench

- Downstream of md5core: consumes its a/b/c/d digest words, the message carried alongside (m_out) and valid_out.
- Compares each digest against a host-loaded 128-bit target hash and captures the first matching 19-byte message.
- Counts hashes checked and holds the match until the host acknowledges it.
- Sits between the md5core pipeline and the host/bus interface logic.

---
 rtl/md5_pkg.sv | 20 ++
 rtl/md5_word_cmp.sv | 21 ++
 rtl/md5_match_checker.sv | 162 ++++++++++++++++
 tb/tb_md5_match_checker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared widths, digest word offsets and checker state encoding for the md5 match checker.
package md5_pkg;

    localparam int MD5_MSG_BITS  = 152;
    localparam int MD5_HASH_BITS = 128;
    localparam int MD5_WORD_BITS = 32;

    // Bit offsets of each digest word inside a packed {a,b,c,d} hash.
    localparam int WORD_A_LSB = 96;
    localparam int WORD_B_LSB = 64;
    localparam int WORD_C_LSB = 32;
    localparam int WORD_D_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MATCHED = 2'd2
    } md5_state_t;

endpackage

// File: rtl/md5_word_cmp.sv
// Registered equality compare of one 32-bit digest word against the target word.
import md5_pkg::*;

module md5_word_cmp (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [MD5_WORD_BITS-1:0] word,
    input  logic [MD5_WORD_BITS-1:0] ref_word,
    output logic                     eq
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            eq <= 1'b0;
        end else if (en) begin
            eq <= (word == ref_word);
        end
    end

endmodule

// File: rtl/md5_match_checker.sv
// Compares md5core digests against a host-loaded target and holds the first matching message.
// Optional build macro MATCH_MULTI_EN adds the saturating match_total counter output.
import md5_pkg::*;

module md5_match_checker #(
    parameter int MSG_BITS = MD5_MSG_BITS,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     target_load,
    input  logic [MD5_HASH_BITS-1:0] target_hash,
    input  logic [31:0]              a_in,
    input  logic [31:0]              b_in,
    input  logic [31:0]              c_in,
    input  logic [31:0]              d_in,
    input  logic [MSG_BITS-1:0]      m_in,
    input  logic                     valid_in,
    input  logic                     match_ack,
    output logic                     armed,
    output logic                     match_found,
    output logic [MSG_BITS-1:0]      match_mesg,
    output logic [CNT_W-1:0]         hash_count
`ifdef MATCH_MULTI_EN
    ,
    output logic [15:0]              match_total
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    md5_state_t                 state;
    logic [MD5_HASH_BITS-1:0]   target_q;

    logic [MD5_HASH_BITS-1:0]   s1_digest;
    logic [MSG_BITS-1:0]        s1_mesg;
    logic                       s1_valid;

    logic [3:0]                 s2_eq;
    logic [MSG_BITS-1:0]        s2_mesg;
    logic                       s2_valid;

    logic                       s3_match;

    // Target register and S1/S2 data path; target_load flushes every valid in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            target_q  <= '0;
            s1_digest <= '0;
            s1_mesg   <= '0;
            s1_valid  <= 1'b0;
            s2_mesg   <= '0;
            s2_valid  <= 1'b0;
        end else if (target_load) begin
            target_q <= target_hash;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (en) begin
            s1_digest <= {a_in, b_in, c_in, d_in};
            s1_mesg   <= m_in;
            s1_valid  <= valid_in;
            s2_mesg   <= s1_mesg;
            s2_valid  <= s1_valid;
        end
    end

    md5_word_cmp u_cmp_a (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .word    (s1_digest[WORD_A_LSB +: MD5_WORD_BITS]),
        .ref_word(target_q[WORD_A_LSB +: MD5_WORD_BITS]),
        .eq      (s2_eq[3])
    );

    md5_word_cmp u_cmp_b (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .word    (s1_digest[WORD_B_LSB +: MD5_WORD_BITS]),
        .ref_word(target_q[WORD_B_LSB +: MD5_WORD_BITS]),
        .eq      (s2_eq[2])
    );

    md5_word_cmp u_cmp_c (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .word    (s1_digest[WORD_C_LSB +: MD5_WORD_BITS]),
        .ref_word(target_q[WORD_C_LSB +: MD5_WORD_BITS]),
        .eq      (s2_eq[1])
    );

    md5_word_cmp u_cmp_d (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .word    (s1_digest[WORD_D_LSB +: MD5_WORD_BITS]),
        .ref_word(target_q[WORD_D_LSB +: MD5_WORD_BITS]),
        .eq      (s2_eq[0])
    );

    // S3: the match is resolved combinationally and consumed by the FSM at the next edge.
    assign s3_match = s2_valid && (&s2_eq);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            armed       <= 1'b0;
            match_found <= 1'b0;
            match_mesg  <= '0;
            hash_count  <= '0;
`ifdef MATCH_MULTI_EN
            match_total <= '0;
`endif
        end else if (target_load) begin
            state       <= ST_ARMED;
            armed       <= 1'b1;
            match_found <= 1'b0;
            hash_count  <= '0;
`ifdef MATCH_MULTI_EN
            match_total <= '0;
`endif
        end else if (en) begin
            if (s1_valid && (state != ST_IDLE) && (hash_count != '1)) begin
                hash_count <= hash_count + CNT_ONE;
            end
`ifdef MATCH_MULTI_EN
            if (s3_match && (state != ST_IDLE) && (match_total != 16'hffff)) begin
                match_total <= match_total + 16'd1;
            end
`endif
            case (state)
                ST_IDLE: begin
                end
                ST_ARMED: begin
                    if (s3_match) begin
                        match_mesg  <= s2_mesg;
                        match_found <= 1'b1;
                        armed       <= 1'b0;
                        state       <= ST_MATCHED;
                    end
                end
                ST_MATCHED: begin
                    // An ack wins over a same-cycle match, which is then dropped.
                    if (match_ack) begin
                        match_found <= 1'b0;
                        armed       <= 1'b1;
                        state       <= ST_ARMED;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    armed       <= 1'b0;
                    match_found <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md5_match_checker.sv
// Directed bench for md5_match_checker: per-cycle compare against a transaction-level model plus literal checks.
module tb_md5_match_checker;

    localparam int MB = 152;

    localparam logic [127:0] T_FOX   = 128'ha2004f37_730b9445_670a738f_a0fc9ee5;
    localparam logic [127:0] T_HELLO = 128'hac98cf84_ae657376_cea165e6_729ddb39;
    localparam logic [127:0] D_NEAR  = 128'hac98cf84_ae657376_cea165e6_729ddb38;

    localparam logic [MB-1:0] MSG_FOX   = "The quick brown fox";
    localparam logic [MB-1:0] MSG_HELLO = "Hello World 1234567";
    localparam logic [MB-1:0] MSG_TEST  = "This is a test. 123";

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          target_load;
    logic [127:0]  target_hash;
    logic [31:0]   a_in, b_in, c_in, d_in;
    logic [MB-1:0] m_in;
    logic          valid_in;
    logic          match_ack;
    logic          armed;
    logic          match_found;
    logic [MB-1:0] match_mesg;
    logic [31:0]   hash_count;
`ifdef MATCH_MULTI_EN
    logic [15:0]   match_total;
`endif

    int checks = 0;
    int errors = 0;
    bit started = 0;

    always #5 clk = ~clk;

    md5_match_checker dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .target_load(target_load),
        .target_hash(target_hash),
        .a_in       (a_in),
        .b_in       (b_in),
        .c_in       (c_in),
        .d_in       (d_in),
        .m_in       (m_in),
        .valid_in   (valid_in),
        .match_ack  (match_ack),
        .armed      (armed),
        .match_found(match_found),
        .match_mesg (match_mesg),
        .hash_count (hash_count)
`ifdef MATCH_MULTI_EN
        ,
        .match_total(match_total)
`endif
    );

    task automatic check(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: digests in flight carry their age in enabled cycles; age 1 is counted, age 2 is compared.
    int            m_state;   // 0 idle, 1 armed, 2 matched
    logic [127:0]  m_target;
    logic [31:0]   m_count;
    logic          m_found;
    logic [MB-1:0] m_mesg;
    logic [15:0]   m_total;
    logic [127:0]  q_dig[$];
    logic [MB-1:0] q_msg[$];
    int            q_age[$];

    always @(posedge clk) begin
        bit            hit;
        logic [MB-1:0] hit_msg;
        hit = 0;
        hit_msg = '0;
        if (!reset_n) begin
            m_state = 0; m_target = '0; m_count = '0; m_found = 0; m_mesg = '0; m_total = '0;
            q_dig.delete(); q_msg.delete(); q_age.delete();
        end else if (target_load) begin
            m_state = 1; m_target = target_hash; m_count = '0; m_found = 0; m_total = '0;
            q_dig.delete(); q_msg.delete(); q_age.delete();
        end else if (en) begin
            for (int i = 0; i < q_age.size(); i++) begin
                if (q_age[i] == 1 && m_state != 0 && m_count != 32'hffffffff) m_count = m_count + 1;
                if (q_age[i] == 2 && q_dig[i] == m_target) begin
                    hit = 1;
                    hit_msg = q_msg[i];
                end
            end
            if (hit && m_state != 0 && m_total != 16'hffff) m_total = m_total + 1;
            if (m_state == 1 && hit) begin
                m_state = 2; m_found = 1; m_mesg = hit_msg;
            end else if (m_state == 2 && match_ack) begin
                m_state = 1; m_found = 0;
            end
            for (int i = q_age.size() - 1; i >= 0; i--) begin
                if (q_age[i] >= 2) begin
                    q_dig.delete(i); q_msg.delete(i); q_age.delete(i);
                end else begin
                    q_age[i] = q_age[i] + 1;
                end
            end
            if (valid_in) begin
                q_dig.push_back({a_in, b_in, c_in, d_in});
                q_msg.push_back(m_in);
                q_age.push_back(1);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("armed", armed, m_state == 1);
            check("match_found", match_found, m_found);
            check("match_mesg", match_mesg, m_mesg);
            check("hash_count", hash_count, m_count);
`ifdef MATCH_MULTI_EN
            check("match_total", match_total, m_total);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [127:0] t);
        target_hash = t;
        target_load = 1'b1;
        tick();
        target_load = 1'b0;
    endtask

    task automatic feed(input logic [127:0] dig, input logic [MB-1:0] msg);
        {a_in, b_in, c_in, d_in} = dig;
        m_in = msg;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic ack();
        match_ack = 1'b1;
        tick();
        match_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1; target_load = 1'b0; target_hash = '0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0; m_in = '0; valid_in = 1'b0; match_ack = 1'b0;
        repeat (2) tick();
        started = 1;
        check("lit_reset_armed", armed, 1'b0);
        check("lit_reset_found", match_found, 1'b0);
        check("lit_reset_mesg", match_mesg, '0);
        check("lit_reset_count", hash_count, 32'd0);
        reset_n = 1'b1;

        // Single digest: match visible 3 cycles after valid_in.
        load(T_FOX);
        check("lit_load_armed", armed, 1'b1);
        feed(T_FOX, MSG_FOX);
        check("lit_fox_n1_found", match_found, 1'b0);
        tick();
        check("lit_fox_n2_found", match_found, 1'b0);
        check("lit_fox_n2_count", hash_count, 32'd1);
        tick();
        check("lit_fox_n3_found", match_found, 1'b1);
        check("lit_fox_mesg", match_mesg, 152'h54686520717569636b2062726f776e20666f78);
        check("lit_fox_count", hash_count, 32'd1);

        // Back-to-back stream, only the middle digest matches (third differs in one bit).
        load(T_HELLO);
        feed(T_FOX, MSG_FOX);
        feed(T_HELLO, MSG_HELLO);
        feed(D_NEAR, MSG_TEST);
        repeat (3) tick();
        check("lit_stream_mesg", match_mesg, 152'h48656c6c6f20576f726c642031323334353637);
        check("lit_stream_count", hash_count, 32'd3);
        check("lit_stream_found", match_found, 1'b1);

        // Match while MATCHED does not overwrite; ack re-arms; re-feed captures again.
        feed(T_HELLO, MSG_TEST);
        repeat (3) tick();
        check("lit_hold_mesg", match_mesg, MSG_HELLO);
        check("lit_hold_count", hash_count, 32'd4);
        ack();
        check("lit_ack_armed", armed, 1'b1);
        check("lit_ack_found", match_found, 1'b0);
        ack();
        check("lit_stray_ack_armed", armed, 1'b1);
        feed(T_HELLO, MSG_TEST);
        repeat (3) tick();
        check("lit_refeed_found", match_found, 1'b1);
        check("lit_refeed_mesg", match_mesg, MSG_TEST);

        // Ack in the same cycle as a new match: ack wins, match lost.
        feed(T_HELLO, MSG_FOX);
        tick();
        ack();
        check("lit_ackwin_found", match_found, 1'b0);
        check("lit_ackwin_mesg", match_mesg, MSG_TEST);
        repeat (2) tick();
        check("lit_ackwin_later", match_found, 1'b0);

        // target_load one cycle after a matching digest flushes it.
        load(T_HELLO);
        feed(T_HELLO, MSG_HELLO);
        load(T_HELLO);
        repeat (3) tick();
        check("lit_flush_found", match_found, 1'b0);
        check("lit_flush_count", hash_count, 32'd0);

        // Stall mid-pipeline for 5 cycles.
        feed(T_HELLO, MSG_FOX);
        en = 1'b0;
        repeat (5) tick();
        check("lit_stall_found", match_found, 1'b0);
        check("lit_stall_count", hash_count, 32'd0);
        en = 1'b1;
        tick();
        check("lit_resume_found", match_found, 1'b0);
        tick();
        check("lit_resume_match", match_found, 1'b1);
        check("lit_resume_mesg", match_mesg, MSG_FOX);
        en = 1'b0;
        ack();
        check("lit_stall_ack", match_found, 1'b1);
        load(T_FOX);
        check("lit_stall_load", armed, 1'b1);
        en = 1'b1;

        // Reset while MATCHED.
        feed(T_FOX, MSG_FOX);
        repeat (3) tick();
        check("lit_pre_reset_found", match_found, 1'b1);
        reset_n = 1'b0;
        tick();
        check("lit_rst_armed", armed, 1'b0);
        check("lit_rst_found", match_found, 1'b0);
        check("lit_rst_mesg", match_mesg, '0);
        check("lit_rst_count", hash_count, 32'd0);
        reset_n = 1'b1;
        tick();

`ifdef MATCH_MULTI_EN
        load(T_HELLO);
        feed(T_HELLO, MSG_HELLO);
        feed(T_HELLO, MSG_FOX);
        feed(T_HELLO, MSG_TEST);
        repeat (3) tick();
        check("lit_multi_total", match_total, 16'd3);
        check("lit_multi_mesg", match_mesg, MSG_HELLO);
        ack();
        check("lit_multi_ack_total", match_total, 16'd3);
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
